// File: rtl/max_pool_stream.sv
// max_pool_stream
// Streaming 2x2 / stride-2 max pooling over one signed feature-map channel.
// Pixels arrive row-major, one per accepted beat. Even rows fold pairwise
// maxima into a half-width line buffer. Odd rows combine that buffer with
// their own pair and emit one pooled pixel per 2x2 window.
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   start                  begin a frame; latches cfg_width / cfg_height
//   cfg_width, cfg_height  frame dimensions (odd values rounded down)
//   in_valid/in_ready/in_data     pixel input stream
//   out_valid/out_ready/out_data  pooled pixel output stream
//   busy                   high while a frame is in progress
//   done                   one-cycle pulse at end of frame
module max_pool_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 64,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DIM_WIDTH-1:0]         cfg_width,
  input  logic [DIM_WIDTH-1:0]         cfg_height,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         busy,
  output logic                         done
);

  localparam int LB_DEPTH = MAX_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_t                         state_q, state_d;
  logic [DIM_WIDTH-1:0]           w_q, w_d, h_q, h_d;
  logic [DIM_WIDTH-1:0]           col_q, col_d, row_q, row_d;
  logic signed [DATA_WIDTH-1:0]   pair_q, pair_d;
  logic                           out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                           done_q, done_d;

  // Line buffer holds max of each horizontal pair of the most recent even row.
  // It is never read before the even row has written it, so it needs no reset.
  logic signed [DATA_WIDTH-1:0]   line_buf [LB_DEPTH];
  logic                           lb_we;
  logic [LB_AW-1:0]               lb_idx;
  logic signed [DATA_WIDTH-1:0]   lb_wdata;

  logic [DIM_WIDTH-1:0]           w_eff, h_eff;
  logic                           accept;

  assign lb_idx    = col_q[LB_AW:1];
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    lb_we       = 1'b0;
    lb_wdata    = smax(pair_q, in_data);
    // A handshake drains the output register; a same-cycle load below refills it.
    out_valid_d = out_valid_q && !out_ready;

    // Round dimensions down to even and clamp width to the line buffer size.
    w_eff = cfg_width & ~DIM_WIDTH'(1);
    h_eff = cfg_height & ~DIM_WIDTH'(1);
    if (w_eff > DIM_WIDTH'(MAX_WIDTH)) w_eff = DIM_WIDTH'(MAX_WIDTH);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (w_eff == '0 || h_eff == '0) begin
            done_d = 1'b1;
          end else begin
            w_d     = w_eff;
            h_d     = h_eff;
            col_d   = '0;
            row_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (!col_q[0]) begin
            pair_d = in_data;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            out_data_d  = smax(line_buf[lb_idx], smax(pair_q, in_data));
            out_valid_d = 1'b1;
          end
          if (col_q == w_q - 1'b1) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == h_q - 1'b1) state_d = FLUSH;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!out_valid_q || out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) line_buf[lb_idx] <= lb_wdata;
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: hand-computed pooled outputs, handshake
// behaviour under backpressure, odd/zero dimensions, ignored start, mid-frame reset.
module tb_max_pool_stream;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        cfg_width = '0;
  logic [7:0]        cfg_height = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_data;
  logic              busy;
  logic              done;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;
  logic signed [7:0] px [0:43];
  logic signed [7:0] outs [$];

  max_pool_stream #(.DATA_WIDTH(8), .MAX_WIDTH(64), .DIM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Record output handshakes and done pulses as the DUT sees them.
  always @(posedge clk) begin
    if (out_valid && out_ready) outs.push_back(out_data);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] w, input logic [7:0] h);
    @(negedge clk);
    cfg_width = w; cfg_height = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Push n pixels from px[base..]. With stall>0, out_ready is held low for
  // stall cycles starting at the first visible output, which must read hold_val.
  task automatic feed(input int base, input int n, input int stall,
                      input logic signed [7:0] hold_val);
    int idx = 0;
    int cyc = 0;
    int st = 0;
    bit started = 0;
    bit acc;
    while (idx < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (st > 0) begin
        st--;
        if (st == 0) out_ready = 1'b1;
      end else if (stall > 0 && !started && out_valid) begin
        started = 1;
        out_ready = 1'b0;
        st = stall;
      end
      in_valid = 1'b1;
      in_data  = px[base + idx];
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_hold_data", out_data, hold_val);
        chk("stall_hold_valid", out_valid, 1);
      end
      acc = in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (acc) idx++;
    end
    chk("feed_beats", idx, n);
    if (stall > 0) chk("stall_seen", started, 1);
    out_ready = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (done) break;
    end
    chk(tag, done, 1);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic chk_outs(input string tag, input int n,
                          input logic signed [7:0] e0, input logic signed [7:0] e1,
                          input logic signed [7:0] e2, input logic signed [7:0] e3);
    logic signed [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_count"}, outs.size(), n);
    for (int i = 0; i < n && i < outs.size(); i++)
      chk({tag, "_data"}, outs[i], e[i]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) px[i] = 8'(i);
    px[16] = 3;   px[17] = -7;  px[18] = 10;  px[19] = 2;
    px[20] = 1;   px[21] = 4;   px[22] = -20; px[23] = 9;
    px[24] = -128; px[25] = -1; px[26] = -50; px[27] = -3;
    for (int i = 0; i < 16; i++) px[28 + i] = 8'(15 - i);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // 4x4 ramp, free-flowing output
    outs.delete(); done_cnt = 0;
    do_start(4, 4);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    feed(0, 16, 0, 0);
    wait_done("t1_done");
    chk_outs("t1", 4, 5, 7, 13, 15);
    chk("t1_done_cnt", done_cnt, 1);

    // 2x2 signed compare
    outs.delete(); done_cnt = 0;
    do_start(2, 2);
    feed(24, 4, 0, 0);
    wait_done("t2_done");
    chk_outs("t2", 1, -1, 0, 0, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // 4x4 with 10-cycle backpressure after first output
    outs.delete(); done_cnt = 0;
    do_start(4, 4);
    feed(0, 16, 10, 5);
    wait_done("t3_done");
    chk_outs("t3", 4, 5, 7, 13, 15);

    // 5x3 -> 4x2, start mid-frame ignored
    outs.delete(); done_cnt = 0;
    do_start(5, 3);
    feed(16, 4, 0, 0);
    do_start(2, 2);
    chk("t4_busy_mid", busy, 1);
    feed(20, 4, 0, 0);
    wait_done("t4_done");
    chk_outs("t4", 2, 4, 10, 0, 0);
    chk("t4_done_cnt", done_cnt, 1);

    // Zero width: immediate done, no run
    outs.delete(); done_cnt = 0;
    do_start(0, 4);
    chk("t5_done", done, 1);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    chk("t5_done_pulse", done, 0);
    // Height 1 rounds to 0
    do_start(4, 1);
    chk("t5b_done", done, 1);
    chk("t5b_busy", busy, 0);
    @(negedge clk);
    chk("t5_outs", outs.size(), 0);
    chk("t5_out_valid", out_valid, 0);

    // Reset mid-frame, then a clean 4x4 frame
    outs.delete(); done_cnt = 0;
    do_start(4, 4);
    feed(0, 6, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt, 0);
    outs.delete();
    do_start(4, 4);
    feed(28, 16, 0, 0);
    wait_done("t6_done2");
    chk_outs("t6", 4, 15, 13, 7, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
